// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment driver for N_DIGITS digits with a built-in refresh prescaler
// and frame-synchronous double buffering. Optional anode dead-time: DISPSCAN_GHOST_GUARD_EN.
module display_scan_mux #(
   parameter int N_DIGITS     = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int ACTIVE_LOW   = 1,
   parameter int GUARD_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7*N_DIGITS-1:0]         seg_in,
   input  logic [N_DIGITS-1:0]           dig_en,
   input  logic                          load,
   output logic [N_DIGITS-1:0]           an_out,
   output logic [6:0]                    seg_out,
   output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
   output logic                          frame_done
);

   localparam int IdxW = $clog2(N_DIGITS);
   localparam int CntW = $clog2(REFRESH_DIV);
   localparam logic [CntW-1:0] LastCnt = CntW'(REFRESH_DIV - 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(N_DIGITS - 1);
`ifdef DISPSCAN_GHOST_GUARD_EN
   localparam int GuardEnable = 1;
`else
   localparam int GuardEnable = 0;
`endif
   localparam int GuardLen = GUARD_CYCLES * GuardEnable;
   // XOR masks that turn logical polarity (1 = lit) into pin polarity.
   localparam logic [N_DIGITS-1:0] AnOff   = {N_DIGITS{ACTIVE_LOW != 0}};
   localparam logic [6:0]          SegMask = {7{ACTIVE_LOW != 0}};

   logic [CntW-1:0]          cnt;
   logic [N_DIGITS-1:0][6:0] stageSeg;
   logic [N_DIGITS-1:0][6:0] activeSeg;
   logic [N_DIGITS-1:0]      stageEn;
   logic [N_DIGITS-1:0]      activeEn;
   logic                     pending;
   logic                     slotEnd;
   logic                     frameWrap;
   logic                     guardBlank;
   logic                     digitLit;
   logic [N_DIGITS-1:0]      anOneHot;
   logic [6:0]               segLogical;

   assign slotEnd    = (cnt == LastCnt);
   assign frameWrap  = slotEnd && (digit_idx == LastIdx);
   assign guardBlank = (GuardLen > 0) && (int'(cnt) < GuardLen);

   always_comb begin
      digitLit            = activeEn[digit_idx] && !guardBlank;
      anOneHot            = '0;
      anOneHot[digit_idx] = digitLit;
      segLogical          = digitLit ? activeSeg[digit_idx] : 7'h00;
   end

   // load is a fire-and-forget strobe (no ready): each asserted cycle overwrites staging,
   // and staging reaches the display only on the next frame wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         digit_idx  <= '0;
         stageSeg   <= '0;
         stageEn    <= '0;
         activeSeg  <= '0;
         activeEn   <= '0;
         pending    <= 1'b0;
         an_out     <= AnOff;
         seg_out    <= SegMask;
         frame_done <= 1'b0;
      end else begin
         cnt <= slotEnd ? '0 : cnt + 1'b1;
         if (slotEnd)
            digit_idx <= (digit_idx == LastIdx) ? '0 : digit_idx + 1'b1;
         frame_done <= frameWrap;
         if (frameWrap && pending) begin
            activeSeg <= stageSeg;
            activeEn  <= stageEn;
         end
         // A load on the wrap edge keeps pending set so the new data shows one frame later.
         if (load) begin
            stageSeg <= seg_in;
            stageEn  <= dig_en;
            pending  <= 1'b1;
         end else if (frameWrap) begin
            pending <= 1'b0;
         end
         an_out  <= anOneHot ^ AnOff;
         seg_out <= segLogical ^ SegMask;
      end
   end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Parametrised time-multiplexed 7-segment driver; generalises the two-digit units/tens select to N_DIGITS digits.
- Built-in refresh prescaler rotates the active digit automatically; no external select is needed.
- Double-buffered pattern registers apply new data only at frame boundaries, so the display never tears.
- Sits between the decoder/segment-pattern logic and the board anode/segment pins.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 100000, clock cycles per digit slot (>=4).
- ACTIVE_LOW, 1, 1 = segments and anodes driven active-low (7'b1000000 shows "0"); 0 = active-high.
- GUARD_CYCLES, 2, anode dead-time at the start of each slot (used only with the optional feature; < REFRESH_DIV).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- seg_in  in  7*N_DIGITS  segment patterns, digit k at [7k+6:7k], bit0 = segment a; always logical polarity (1 = lit)
- dig_en  in  N_DIGITS  per-digit enable; a disabled digit is blanked
- load  in  1  one-cycle strobe: capture seg_in/dig_en into the staging register
- an_out  out  N_DIGITS  anode drives, one-hot active (polarity per ACTIVE_LOW)
- seg_out  out  7  segment drive for the active digit (polarity per ACTIVE_LOW)
- digit_idx  out  $clog2(N_DIGITS)  index of the digit currently driven
- frame_done  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- All state is updated on the rising edge of clk; rst is sampled synchronously, has priority over everything, and may be asserted mid-slot or mid-frame.
- Reset values:
  - slot counter cnt = 0, digit_idx = 0.
  - Staging and active registers cleared: all segments off, all dig_en = 0.
  - an_out = all inactive (all 1s if ACTIVE_LOW, otherwise all 0s).
  - seg_out = all off (7'h7F if ACTIVE_LOW, otherwise 7'h00).
  - frame_done = 0, pending flag = 0.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1.
  - At cnt == REFRESH_DIV-1: cnt -> 0 and digit_idx -> digit_idx+1, wrapping N_DIGITS-1 -> 0.
- Frame end: on the same edge where digit_idx wraps from N_DIGITS-1 to 0:
  - frame_done = 1 for exactly that cycle.
  - If the pending flag is set: active <= staging and pending <= 0.
- Load:
  - load = 1 captures seg_in and dig_en into staging and sets pending.
  - Several loads within one frame: the last one wins.
  - load on the same edge as a frame wrap: the staging register takes the new data, active takes the previous staging contents, and pending stays 1.
- Outputs are registered and follow digit_idx with a one-cycle latency.
  - an_out asserts only bit digit_idx, and only if active dig_en[digit_idx] = 1; otherwise all anodes are inactive.
  - seg_out = active pattern[digit_idx], inverted when ACTIVE_LOW; it is forced to "off" when the digit is disabled.
- digit_idx is the raw register value, with no extra latency.
- Non-power-of-two N_DIGITS: index values >= N_DIGITS are never reached.

Optional Feature:
- Macro: DISPSCAN_GHOST_GUARD_EN.
- Defined: for cnt < GUARD_CYCLES in each slot, an_out is held all-inactive and seg_out is held off (ghosting suppression). The normal drive resumes on the cycle after cnt reaches GUARD_CYCLES, consistent with the one-cycle output latency.
- Undefined: the anode is driven for the full slot and GUARD_CYCLES is ignored.

Test Plan:
- Reset: rst = 1 for 3 cycles -> an_out = 4'b1111, seg_out = 7'h7F, digit_idx = 0, frame_done = 0. Test parameters: N_DIGITS = 4, REFRESH_DIV = 4, ACTIVE_LOW = 1.
- Rotation: after reset, digit_idx steps 0,1,2,3,0 every 4 cycles; frame_done pulses once every 16 cycles, on the 3 -> 0 edge.
- Load with all digits enabled: load seg_in digit0 = 7'h3F, digit1 = 7'h06, dig_en = 4'hF, mid-frame.
  - Outputs stay blank until the next frame_done.
  - In the following frame, the slot for idx 0 gives an_out = 4'b1110, seg_out = 7'b1000000.
  - The slot for idx 1 gives an_out = 4'b1101, seg_out = 7'b1111001.
- Digit disable: dig_en = 4'b1101 loaded -> during the idx 1 slot, an_out = 4'b1111 and seg_out = 7'h7F.
- Double load and edge case:
  - Two loads in one frame (patterns A then B) -> only B is displayed next frame.
  - A load coinciding with the frame_done edge -> the old staging data is shown next frame and the new data the frame after.
- Guard (with DISPSCAN_GHOST_GUARD_EN, GUARD_CYCLES = 2): for each slot, anodes are inactive for the first 2 cycles, then active for 2; rst asserted mid-slot returns all outputs to their reset values on the next edge.
